// File: rtl/shift_sequencer_pkg.sv
// Shared sequencer/generator definitions: FSM state encoding and default window lengths.
// Pure declarations; no logic, no latency, no flow control.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STAT = 2'd1,
    DYN  = 2'd2,
    GAP  = 2'd3
  } seq_state_t;

  localparam int SIZESRSTAT_DEF = 88;
  localparam int SIZESRDYN_DEF  = 16;
  localparam int CNTW_DEF       = 7;

  // A request for zero frames still runs one frame.
  function automatic logic [7:0] eff_repeat(input logic [7:0] r);
    return (r == 8'd0) ? 8'd1 : r;
  endfunction

endpackage

// File: rtl/shift_sequencer_window_counter.sv
// Loadable down-counter with terminal-count flag; times every window and gap of the sequencer.
// Load/decrement take effect at the next edge; tc is combinational from the count; no backpressure.
module window_counter #(
  parameter int W = 7
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Frames of SIZESRSTAT static + SIZESRDYN dynamic shift cycles, GAP_LEN idle cycles between frames.
// Outputs registered, valid the cycle after the deciding edge; START ignored while busy, ABORT always wins.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int SIZESRSTAT = SIZESRSTAT_DEF,
  parameter int SIZESRDYN  = SIZESRDYN_DEF,
  parameter int CNTW       = CNTW_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] REPEAT,
  input  logic [3:0] GAP_LEN,
  output logic       SELSTAT,
  output logic       SELDYN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ABORTED,
  output logic [7:0] FRAME_CNT
);

  localparam logic [CNTW-1:0] STAT_LD = CNTW'(SIZESRSTAT - 1);
  localparam logic [CNTW-1:0] DYN_LD  = CNTW'(SIZESRDYN - 1);

  seq_state_t      state, state_nxt;
  logic [7:0]      rep_q;
  logic [3:0]      gap_q;
  logic            cnt_load, cnt_dec, cnt_tc;
  logic [CNTW-1:0] cnt_val;
  logic            latch, fc_clr, fc_inc, done_nxt, abort_nxt;
  logic            last_frame;

  assign last_frame = (FRAME_CNT == (rep_q - 8'd1));

  window_counter #(.W(CNTW)) u_win (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    latch     = 1'b0;
    fc_clr    = 1'b0;
    fc_inc    = 1'b0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = STAT;
          cnt_load  = 1'b1;
          cnt_val   = STAT_LD;
          latch     = 1'b1;
          fc_clr    = 1'b1;
        end
      end
      STAT: begin
        if (cnt_tc) begin
          state_nxt = DYN;
          cnt_load  = 1'b1;
          cnt_val   = DYN_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DYN: begin
        if (cnt_tc) begin
          fc_inc = 1'b1;
          if (last_frame) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (gap_q == 4'd0) begin
            state_nxt = STAT;
            cnt_load  = 1'b1;
            cnt_val   = STAT_LD;
          end else begin
            state_nxt = GAP;
            cnt_load  = 1'b1;
            cnt_val   = CNTW'(gap_q - 4'd1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_tc) begin
          state_nxt = STAT;
          cnt_load  = 1'b1;
          cnt_val   = STAT_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides whatever the running state decided, including a frame completion.
    if (ABORT && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      fc_inc    = 1'b0;
      done_nxt  = 1'b0;
      abort_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rep_q <= 8'd1;
      gap_q <= 4'd0;
    end else if (latch) begin
      rep_q <= eff_repeat(REPEAT);
      gap_q <= GAP_LEN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SELSTAT   <= 1'b0;
      SELDYN    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ABORTED   <= 1'b0;
      FRAME_CNT <= 8'd0;
    end else begin
      SELSTAT <= (state_nxt == STAT);
      SELDYN  <= (state_nxt == DYN);
      BUSY    <= (state_nxt != IDLE);
      DONE    <= done_nxt;
      ABORTED <= abort_nxt;
      if (fc_clr) begin
        FRAME_CNT <= 8'd0;
      end else if (fc_inc) begin
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: the driver expands each accepted sequence into per-cycle expected outputs,
// a negedge monitor pops one entry per cycle and compares.
module tb_shift_sequencer;

  localparam int STAT_N = 88;
  localparam int DYN_N  = 16;

  logic       CLK, RST_N, START, ABORT;
  logic [7:0] REPEAT;
  logic [3:0] GAP_LEN;
  logic       SELSTAT, SELDYN, BUSY, DONE, ABORTED;
  logic [7:0] FRAME_CNT;

  typedef struct packed {
    logic       selstat;
    logic       seldyn;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] fc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_fc;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;

  shift_sequencer #(
    .SIZESRSTAT (STAT_N),
    .SIZESRDYN  (DYN_N),
    .CNTW       (7)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .ABORT     (ABORT),
    .REPEAT    (REPEAT),
    .GAP_LEN   (GAP_LEN),
    .SELSTAT   (SELSTAT),
    .SELDYN    (SELDYN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ABORTED   (ABORTED),
    .FRAME_CNT (FRAME_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic exp_t mk(input logic ss, input logic sd, input logic b,
                              input logic d, input logic ab, input logic [7:0] fc);
    exp_t e;
    e = {ss, sd, b, d, ab, fc};
    return e;
  endfunction

  function automatic exp_t actual();
    return mk(SELSTAT, SELDYN, BUSY, DONE, ABORTED, FRAME_CNT);
  endfunction

  task automatic fail_msg(input string name, input exp_t act, input exp_t req);
    n_fail++;
    if (n_fail <= 20)
      $display("FAIL %s cycle %0d: got {ss,sd,busy,done,abrt,fc}=%b,%b,%b,%b,%b,%0d required %b,%b,%b,%b,%b,%0d",
               name, cyc, act.selstat, act.seldyn, act.busy, act.done, act.aborted, act.fc,
               req.selstat, req.seldyn, req.busy, req.done, req.aborted, req.fc);
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST_N) begin
      n_checks++;
      if (SELSTAT && SELDYN) fail_msg("sel_exclusive", actual(), mk(0, 0, BUSY, DONE, ABORTED, FRAME_CNT));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (actual() !== e) fail_msg("scoreboard", actual(), e);
      end
    end
  end

  // Reference: a sequence is REPEAT (min 1) frames of 88 static + 16 dynamic cycles,
  // gaps only between frames, then one DONE cycle with the final frame count.
  task automatic push_sequence(input logic [7:0] r, input logic [3:0] g);
    int         re;
    logic [7:0] fc;
    re = (r == 8'd0) ? 1 : int'(r);
    fc = 8'd0;
    for (int f = 0; f < re; f++) begin
      for (int i = 0; i < STAT_N; i++) exp_q.push_back(mk(1, 0, 1, 0, 0, fc));
      for (int i = 0; i < DYN_N; i++)  exp_q.push_back(mk(0, 1, 1, 0, 0, fc));
      fc = fc + 8'd1;
      if (f < re - 1)
        for (int i = 0; i < int'(g); i++) exp_q.push_back(mk(0, 0, 1, 0, 0, fc));
    end
    exp_q.push_back(mk(0, 0, 0, 1, 0, fc));
    model_fc = fc;
  endtask

  // Called at posedge+1; exp_q[0] is the expected output of the current cycle.
  task automatic step(input logic s, input logic a, input logic [7:0] r, input logic [3:0] g);
    logic [7:0] fc;
    if (exp_q.size() == 0) exp_q.push_back(mk(0, 0, 0, 0, 0, model_fc));
    if (a && exp_q[0].busy) begin
      fc = exp_q[0].fc;
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      exp_q.push_back(mk(0, 0, 0, 0, 1, fc));
      model_fc = fc;
    end else if (s && !exp_q[0].busy) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      push_sequence(r, g);
    end
    START   = s;
    ABORT   = a;
    REPEAT  = r;
    GAP_LEN = g;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'd0, 4'd0);
  endtask

  task automatic run_to_done();
    int k;
    k = 0;
    while (!(exp_q.size() > 0 && exp_q[0].done) && k < 5000) begin
      step(0, 0, 8'd0, 4'd0);
      k++;
    end
    n_checks++;
    if (k >= 5000) begin
      n_fail++;
      $display("FAIL done_timeout cycle %0d: waited %0d cycles, required a DONE cycle", cyc, k);
    end
  endtask

  task automatic check_reset_zero(input string name);
    n_checks++;
    if (actual() !== mk(0, 0, 0, 0, 0, 8'd0)) fail_msg(name, actual(), mk(0, 0, 0, 0, 0, 8'd0));
  endtask

  task automatic do_reset_mid();
    RST_N = 1'b0;
    START = 1'b0;
    ABORT = 1'b0;
    #1;
    check_reset_zero("async_reset");
    exp_q.delete();
    model_fc = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin : watchdog
    #5000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : driver
    logic [7:0] r;
    logic [3:0] g;
    int         w, p;
    RST_N = 1'b1; START = 1'b0; ABORT = 1'b0; REPEAT = 8'd0; GAP_LEN = 4'd0;
    model_fc = 8'd0;
    #2 RST_N = 1'b0;
    #1 check_reset_zero("power_on_reset");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Single frame immediately after reset release, then REPEAT=0 started on the DONE cycle.
    step(1, 0, 8'd1, 4'd0);
    run_to_done();
    step(1, 0, 8'd0, 4'd3);
    run_to_done();
    idle(3);

    // Three frames with 5-cycle gaps; a mid-sequence START with other parameters is ignored.
    step(1, 0, 8'd3, 4'd5);
    idle(50);
    step(1, 0, 8'd7, 4'd0);
    idle(60);
    step(1, 0, 8'd1, 4'd1);
    run_to_done();
    idle(2);

    // Abort during the static window, then ABORT together with START during the dynamic window.
    step(1, 0, 8'd2, 4'd1);
    idle(39);
    step(0, 1, 8'd0, 4'd0);
    idle(3);
    step(1, 0, 8'd1, 4'd0);
    idle(100);
    step(1, 1, 8'd5, 4'd5);
    step(0, 1, 8'd0, 4'd0);
    idle(3);

    // Reset during the dynamic window of frame 2, then a clean single frame.
    step(1, 0, 8'd3, 4'd2);
    idle(STAT_N + DYN_N + 2 + STAT_N + 5);
    do_reset_mid();
    step(1, 0, 8'd1, 4'd0);
    run_to_done();
    idle(2);

    for (int i = 0; i < 40; i++) begin
      r = 8'($urandom_range(0, 4));
      g = 4'($urandom_range(0, 15));
      step(1, 0, r, g);
      w = $urandom_range(0, 400);
      for (int j = 0; j < w; j++) begin
        p = $urandom_range(0, 999);
        if (p < 3)       step(0, 1, 8'd0, 4'd0);
        else if (p < 10) step(1, 0, 8'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        else             step(0, 0, 8'd0, 4'd0);
      end
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
